// File: rtl/ahb2apb_bridge_pkg.sv
// Shared encodings for the AHB-to-APB bridge: AHB HTRANS/HRESP codes
// and bridge FSM states.
package ahb2apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } br_state_e;

  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_psel_decoder.sv
// One-hot APB peripheral select from the registered index.
module apb_psel_decoder #(
  parameter int NUM_PSLV = 4,
  parameter int IDX_W    = $clog2(NUM_PSLV)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_PSLV-1:0] psel
);

  always_comb begin
    psel = '0;
    if (en) psel[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB slave to APB master bridge, one APB access per AHB transfer.
// Define AHB2APB_APB3_EN to honour PREADY wait states and PSLVERR.
module ahb2apb_bridge
  import ahb2apb_bridge_pkg::*;
#(
  parameter int NUM_PSLV = 4,
  parameter int PADDR_W  = 12,
  parameter int PSEL_LSB = 12
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [31:0]              HADDR,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [15:0]              HSPLIT,
  output logic [31:0]              HRDATA,
  output logic [PADDR_W-1:0]       PADDR,
  output logic [NUM_PSLV-1:0]      PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [31:0]              PWDATA,
  input  logic [32*NUM_PSLV-1:0]   PRDATA,
  input  logic [NUM_PSLV-1:0]      PREADY,
  input  logic [NUM_PSLV-1:0]      PSLVERR
);

  localparam int IDX_W = $clog2(NUM_PSLV);

  br_state_e          state;
  logic               hreadyout_q;
  logic [1:0]         hresp_q;
  logic [31:0]        hrdata_q;
  logic               psel_en;
  logic               penable_q;
  logic               pwrite_q;
  logic [PADDR_W-1:0] paddr_q;
  logic [IDX_W-1:0]   idx_q;

  logic        acc;
  logic        done_c;
  logic        err_c;
  logic [31:0] prdata_sel;
  logic        unused_ok;

  assign acc = HSEL & htrans_active(HTRANS) & HREADY;
  assign prdata_sel = PRDATA[{idx_q, 5'd0} +: 32];

`ifdef AHB2APB_APB3_EN
  assign done_c    = PREADY[idx_q];
  assign err_c     = PSLVERR[idx_q];
  assign unused_ok = ^{HSIZE, HADDR};
`else
  assign done_c    = 1'b1;
  assign err_c     = 1'b0;
  assign unused_ok = ^{HSIZE, HADDR, PREADY, PSLVERR};
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      psel_en     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      idx_q       <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          hresp_q     <= HRESP_OKAY;
          hreadyout_q <= 1'b1;
          if (acc) begin
            state       <= ST_SETUP;
            psel_en     <= 1'b1;
            hreadyout_q <= 1'b0;
            paddr_q     <= HADDR[PADDR_W-1:0];
            idx_q       <= HADDR[PSEL_LSB +: IDX_W];
            pwrite_q    <= HWRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state     <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (done_c) begin
            psel_en   <= 1'b0;
            penable_q <= 1'b0;
            if (!pwrite_q) hrdata_q <= prdata_sel;
            if (err_c) begin
              state   <= ST_ERR1;
              hresp_q <= HRESP_ERROR;
            end else begin
              state       <= ST_DONE;
              hreadyout_q <= 1'b1;
            end
          end
        end
        // Two-cycle ERROR: first with HREADYOUT low, then high.
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  apb_psel_decoder #(
    .NUM_PSLV(NUM_PSLV),
    .IDX_W   (IDX_W)
  ) u_psel_dec (
    .idx (idx_q),
    .en  (psel_en),
    .psel(PSEL)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HSPLIT    = '0;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: directed and random AHB
// transfers checked against a transfer-level model.
module tb_ahb2apb_bridge;

  localparam int N        = 4;
  localparam int PADDR_W  = 12;
  localparam int PSEL_LSB = 12;
  localparam int IDX_W    = 2;

  logic               HCLK = 1'b0;
  logic               HRESETn = 1'b0;
  logic               HSEL;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [2:0]         HSIZE;
  logic [31:0]        HADDR;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [1:0]         HRESP;
  logic [15:0]        HSPLIT;
  logic [31:0]        HRDATA;
  logic [PADDR_W-1:0] PADDR;
  logic [N-1:0]       PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [32*N-1:0]    PRDATA;
  logic [N-1:0]       PREADY;
  logic [N-1:0]       PSLVERR;

  logic               hready_block;
  logic [31:0]        prd [N];

  logic [31:0] t_addr [$];
  logic [31:0] t_wd [$];
  logic        t_wr [$];
  logic [31:0] exp_hrdata;
  int          n_chk;
  int          n_fail;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT & ~hready_block;

  always_comb begin
    PRDATA = '0;
    for (int k = 0; k < N; k++) PRDATA[32*k +: 32] = prd[k];
  end

  ahb2apb_bridge #(
    .NUM_PSLV(N),
    .PADDR_W (PADDR_W),
    .PSEL_LSB(PSEL_LSB)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HSPLIT   (HSPLIT),
    .HRDATA   (HRDATA),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w,
                      input logic [31:0] d);
    t_addr.push_back(a);
    t_wr.push_back(w);
    t_wd.push_back(d);
  endtask

  // Master for queued transfers, pipelining the next address into
  // each data phase. For reads, a nonzero t_wd forces the PRDATA value.
  task automatic run_queue();
    int n;
    n = t_addr.size();
    if (n == 0) return;
    @(posedge HCLK); #1;
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HADDR = t_addr[0];
    HWRITE = t_wr[0];
    @(negedge HCLK);
    chk("idle_ready", 64'(HREADYOUT), 64'd1);
    for (int i = 0; i < n; i++) begin
      int cyc;
      logic done;
      logic [31:0] a;
      logic [IDX_W-1:0] sidx;
      logic [N-1:0] exp_sel;
      a = t_addr[i];
      sidx = a[PSEL_LSB +: IDX_W];
      exp_sel = N'(1) << sidx;
      @(posedge HCLK); #1;
      HWDATA = t_wd[i];
      for (int k = 0; k < N; k++) prd[k] = $urandom;
      if (!t_wr[i] && t_wd[i] != 32'd0) prd[sidx] = t_wd[i];
`ifdef AHB2APB_APB3_EN
      PREADY = '1;
      PSLVERR = '0;
`else
      PREADY = N'($urandom);
      PSLVERR = N'($urandom);
`endif
      if (!t_wr[i]) exp_hrdata = prd[sidx];
      if (i + 1 < n) begin
        HSEL = 1'b1;
        HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
        HADDR = t_addr[i+1];
        HWRITE = t_wr[i+1];
      end else begin
        HSEL = 1'($urandom);
        HTRANS = 2'b00;
        HADDR = $urandom;
      end
      cyc = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge HCLK);
        cyc++;
        if (cyc == 1) begin
          chk("setup_psel", 64'(PSEL), 64'(exp_sel));
          chk("setup_penable", 64'(PENABLE), 64'd0);
          chk("setup_paddr", 64'(PADDR), 64'(a[PADDR_W-1:0]));
          chk("setup_pwrite", 64'(PWRITE), 64'(t_wr[i]));
          chk("setup_hready", 64'(HREADYOUT), 64'd0);
        end
        if (cyc == 2) begin
          chk("access_psel", 64'(PSEL), 64'(exp_sel));
          chk("access_penable", 64'(PENABLE), 64'd1);
          chk("access_paddr", 64'(PADDR), 64'(a[PADDR_W-1:0]));
          chk("access_pwdata", 64'(PWDATA), 64'(t_wd[i]));
        end
        if (HREADYOUT) done = 1'b1;
        else if (cyc >= 20) done = 1'b1;
      end
      chk("data_phase_len", 64'(cyc), 64'd3);
      chk("done_psel", 64'(PSEL), 64'd0);
      chk("done_penable", 64'(PENABLE), 64'd0);
      chk("done_hresp", 64'(HRESP), 64'd0);
      chk("hrdata", 64'(HRDATA), 64'(exp_hrdata));
    end
    t_addr.delete();
    t_wr.delete();
    t_wd.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_hrdata = 32'd0;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE = 3'b010;
    HADDR = 32'd0;
    HWDATA = 32'd0;
    hready_block = 1'b0;
    PREADY = '1;
    PSLVERR = '0;
    for (int k = 0; k < N; k++) prd[k] = 32'd0;

    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_hrdata", 64'(HRDATA), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwrite", 64'(PWRITE), 64'd0);
    chk("hsplit", 64'(HSPLIT), 64'd0);

    // BUSY, unselected NONSEQ and NONSEQ with HREADY low never start APB
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000;
    repeat (2) @(negedge HCLK);
    chk("busy_ready", 64'(HREADYOUT), 64'd1);
    chk("busy_psel", 64'(PSEL), 64'd0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b10;
    repeat (2) @(negedge HCLK);
    chk("nosel_psel", 64'(PSEL), 64'd0);
    @(posedge HCLK); #1;
    HSEL = 1'b1; hready_block = 1'b1;
    repeat (2) @(negedge HCLK);
    chk("hready_low_psel", 64'(PSEL), 64'd0);
    chk("hready_low_rdy", 64'(HREADYOUT), 64'd1);
    @(posedge HCLK); #1;
    hready_block = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;

    push(32'h0000_2010, 1'b1, 32'hDEAD_BEEF);
    run_queue();
    push(32'h0000_3004, 1'b0, 32'h1234_5678);
    run_queue();
    push(32'h0000_1000, 1'b0, 32'h0BAD_F00D);
    push(32'h0000_0000, 1'b1, 32'hCAFE_0001);
    push(32'hFFFF_7ABC, 1'b0, 32'd0);
    push(32'h0000_6004, 1'b1, 32'h5555_AAAA);
    run_queue();

    for (int j = 0; j < 16; j++) push($urandom, 1'($urandom), $urandom);
    run_queue();

    // Asynchronous reset in the middle of an ACCESS cycle
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_2000; HWRITE = 1'b0;
    PREADY = '0; PSLVERR = '0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("pre_rst_penable", 64'(PENABLE), 64'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_psel", 64'(PSEL), 64'd0);
    chk("async_penable", 64'(PENABLE), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    exp_hrdata = 32'd0;
    @(negedge HCLK);
    chk("post_rst_ready", 64'(HREADYOUT), 64'd1);
    chk("post_rst_psel", 64'(PSEL), 64'd0);
    chk("post_rst_hrdata", 64'(HRDATA), 64'd0);
    PREADY = '1;

`ifdef AHB2APB_APB3_EN
    // PREADY low for three ACCESS cycles, then completion with PSLVERR
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1040; HWRITE = 1'b0;
    PREADY = '0; PSLVERR = '0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("apb3_setup_pen", 64'(PENABLE), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      chk("apb3_access_pen", 64'(PENABLE), 64'd1);
      chk("apb3_access_rdy", 64'(HREADYOUT), 64'd0);
    end
    PREADY = '1; PSLVERR = '1;
    @(negedge HCLK);
    PSLVERR = '0;
    chk("err1_ready", 64'(HREADYOUT), 64'd0);
    chk("err1_hresp", 64'(HRESP), 64'd1);
    chk("err1_psel", 64'(PSEL), 64'd0);
    @(negedge HCLK);
    chk("err2_ready", 64'(HREADYOUT), 64'd1);
    chk("err2_hresp", 64'(HRESP), 64'd1);
    @(negedge HCLK);
    chk("err_idle_ready", 64'(HREADYOUT), 64'd1);
    chk("err_idle_hresp", 64'(HRESP), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
AHB slave sitting on one slave port of the ahb interconnect (e.g. the HSEL_S2 / HREADY_S2 / HRESP_S2 / HRDATA_S2 group). It converts each AHB transfer into an APB SETUP/ACCESS sequence toward NUM_PSLV APB peripherals. It decodes the peripheral select from the address, muxes read data back, and stalls the AHB data phase with HREADYOUT until the APB access completes.

Parameters:
NUM_PSLV, 4, number of APB peripherals; must be a power of two, range 2..16.
PADDR_W, 12, width of PADDR; PADDR = HADDR[PADDR_W-1:0].
PSEL_LSB, 12, lowest HADDR bit of the peripheral index; index = HADDR[PSEL_LSB +: log2(NUM_PSLV)].

Ports:
HCLK  in  1  clock; all logic rising-edge.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from the interconnect decoder.
HTRANS  in  2  AHB transfer type.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size; ignored, all APB accesses are 32-bit.
HADDR  in  32  address.
HWDATA  in  32  write data.
HREADY  in  1  bus-level HREADY returned by the interconnect.
HREADYOUT  out  1  this slave's ready output.
HRESP  out  2  response: OKAY=2'b00, ERROR=2'b01.
HSPLIT  out  16  tied to 0.
HRDATA  out  32  registered read data.
PADDR  out  PADDR_W  APB address.
PSEL  out  NUM_PSLV  one-hot APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  32  APB write data.
PRDATA  in  32*NUM_PSLV  flattened read data; slave k occupies bits [32k+31:32k].
PREADY  in  NUM_PSLV  per-slave ready; used only with the optional feature.
PSLVERR  in  NUM_PSLV  per-slave error; used only with the optional feature.

Behaviour:
- Clock and reset: single clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0.
- Reset is asynchronous. Asserting it mid-access drops PSEL and PENABLE immediately, and the in-flight transfer is abandoned.
- Accept condition: acc = HSEL & HTRANS[1] & HREADY. This covers NONSEQ and SEQ. IDLE and BUSY get a zero-wait OKAY.
- On acc, register HADDR-derived PADDR, the peripheral index, and HWRITE.
- States and transitions:
  - IDLE: HREADYOUT=1. On acc -> SETUP.
  - SETUP: PSEL[idx]=1, PENABLE=0, HREADYOUT=0. Always -> ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1, HREADYOUT=0. On completion, capture HRDATA=PRDATA[idx] (reads only; HRDATA is held on writes), drop PSEL/PENABLE, -> DONE.
  - DONE: HREADYOUT=1, HRESP=OKAY. On acc (a pipelined next transfer) -> SETUP; else -> IDLE.
- PWDATA is driven from HWDATA. It is valid and held throughout SETUP/ACCESS because the master holds HWDATA while HREADYOUT=0.
- Latency: a zero-wait APB access completes the AHB data phase in 3 cycles (SETUP, ACCESS, DONE). Back-to-back transfers: 3 cycles each, with no IDLE bubble.
- PADDR and PWRITE stay stable from SETUP through ACCESS, and hold their last value otherwise.
- Index wrap: only log2(NUM_PSLV) bits are decoded, so higher addresses alias onto slaves modulo NUM_PSLV.

Optional Feature:
AHB2APB_APB3_EN
- Defined:
  - ACCESS completes only when PREADY[idx]=1; it extends indefinitely otherwise.
  - PSLVERR[idx]=1 at completion -> ERR1 (HREADYOUT=0, HRESP=ERROR) -> ERR2 (HREADYOUT=1, HRESP=ERROR).
  - ERR2 exits like DONE: acc -> SETUP, else -> IDLE.
- Undefined: PREADY and PSLVERR are unconnected internally; ACCESS always completes in one cycle; HRESP is always OKAY.

Decomposition:
- Shared defines in def_ahb.v: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ) and HRESP encodings (OKAY/ERROR/RETRY/SPLIT).
- New def_apb.v: bridge state encodings (IDLE, SETUP, ACCESS, DONE, ERR1, ERR2).
- One sub-module: apb_psel_decoder, taking the registered index plus an enable and producing one-hot PSEL.
- PRDATA/PREADY/PSLVERR selection stays inline.

Test Plan:
- Reset release, no traffic: HREADYOUT=1, HRESP=00, PSEL=0, PENABLE=0, HRDATA=0.
- Write HADDR=0x0000_2010, HWDATA=0xDEADBEEF: PSEL=4'b0100 and PADDR=0x010 in SETUP; PENABLE=1 in ACCESS; PWDATA=0xDEADBEEF; HREADYOUT low for 2 cycles, then high.
- Read HADDR=0x0000_3004 with PRDATA slave 3 = 0x12345678: HRDATA=0x12345678 in DONE with HREADYOUT=1; 3-cycle data phase.
- Back-to-back read 0x1000 then write 0x0000 (pipelined address in DONE): SETUP follows DONE directly; PSEL goes 0010 -> 0 -> 0001; no IDLE cycle between.
- AHB2APB_APB3_EN, PREADY low 3 cycles, then PSLVERR=1: ACCESS lasts 4 cycles; then ERR1 (HREADYOUT=0, HRESP=01); then ERR2 (HREADYOUT=1, HRESP=01); then IDLE.
- HRESETn asserted during ACCESS: PSEL/PENABLE=0 asynchronously; after release, state is IDLE and HREADYOUT=1.
